// File: rtl/div2_sequencer_if.sv
// Memory-port and Start/Ack launch signals shared between the division
// sequencer (master) and the host/data-memory side (slave).
interface div2_sequencer_if #(
    parameter int AW = 8
);
    logic          Start;
    logic          Ack;
    logic          Busy;
    logic [AW-1:0] MemAddr;
    logic          MemWrEn;
    logic [7:0]    MemWrData;
    logic [7:0]    MemRdData;

    modport master (
        input  Start, MemRdData,
        output Ack, Busy, MemAddr, MemWrEn, MemWrData
    );

    modport slave (
        output Start, MemRdData,
        input  Ack, Busy, MemAddr, MemWrEn, MemWrData
    );
endinterface

// File: rtl/div2_sequencer.sv
// Fetches a 16-bit dividend and 8-bit divisor, produces a 16.8 fixed-point
// quotient by bit-serial restoring division and writes it back as 3 bytes.
// state  | meaning
// IDLE   | waiting for first launch
// LD_HI  | read dividend[15:8]
// LD_LO  | read dividend[7:0]
// LD_DIV | read divisor; zero divisor bypasses DIVIDE with all-ones quotient
// DIVIDE | one quotient bit per cycle (24, or 25 with guard bit)
// WR_HI  | write q[23:16]
// WR_MID | write q[15:8]
// WR_LO  | write q[7:0]
// DONE   | Ack held; a new launch restarts at LD_HI
module div2_sequencer #(
    parameter int            AW           = 8,
    parameter logic [AW-1:0] DIN_HI_ADDR  = AW'(0),
    parameter logic [AW-1:0] DIN_LO_ADDR  = AW'(1),
    parameter logic [AW-1:0] DIVISOR_ADDR = AW'(2),
    parameter logic [AW-1:0] RES_ADDR     = AW'(4),
    parameter int            ROUND        = 0
) (
    input logic               Clk,
    input logic               Reset,
    div2_sequencer_if.master  bus
);

    localparam int         QW       = 24 + ((ROUND != 0) ? 1 : 0);
    localparam logic [4:0] CNT_LOAD = 5'(QW - 1);

    typedef enum logic [3:0] {
        IDLE, LD_HI, LD_LO, LD_DIV, DIVIDE, WR_HI, WR_MID, WR_LO, DONE
    } state_t;

    state_t          state, state_nxt;
    logic            start_q;
    logic [15:0]     dividend;
    logic [7:0]      divisor;
    logic [23:0]     num;
    logic [7:0]      rem;
    logic [QW-1:0]   quo;
    logic [4:0]      cnt;

    logic            launch;
    logic [8:0]      rem_shift;
    logic            rem_ge;
    logic [7:0]      rem_diff;
    logic [23:0]     quot;
    logic            guard;
    logic [23:0]     result;

    assign launch    = bus.Start && !start_q;
    assign rem_shift = {rem, num[23]};
    assign rem_ge    = rem_shift >= {1'b0, divisor};
    // True difference is below the divisor, so 8 bits are enough.
    assign rem_diff  = rem_shift[7:0] - divisor;

    assign quot   = quo[QW-1 -: 24];
    assign guard  = (ROUND != 0) ? quo[0] : 1'b0;
    assign result = (quot == 24'hFF_FFFF) ? quot : quot + {23'd0, guard};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            dividend <= '0;
            divisor  <= '0;
            num      <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= bus.Start;
            case (state)
                LD_HI: dividend[15:8] <= bus.MemRdData;
                LD_LO: dividend[7:0]  <= bus.MemRdData;
                LD_DIV: begin
                    divisor <= bus.MemRdData;
                    num     <= {dividend, 8'h00};
                    rem     <= '0;
                    cnt     <= CNT_LOAD;
                    if (bus.MemRdData == 8'h00) quo <= '1;
                end
                DIVIDE: begin
                    num <= {num[22:0], 1'b0};
                    rem <= rem_ge ? rem_diff : rem_shift[7:0];
                    quo <= {quo[QW-2:0], rem_ge};
                    cnt <= cnt - 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.Ack       = 1'b0;
        bus.Busy      = 1'b0;
        bus.MemAddr   = '0;
        bus.MemWrEn   = 1'b0;
        bus.MemWrData = '0;
        case (state)
            IDLE: if (launch) state_nxt = LD_HI;
            LD_HI: begin
                bus.Busy    = 1'b1;
                bus.MemAddr = DIN_HI_ADDR;
                state_nxt   = LD_LO;
            end
            LD_LO: begin
                bus.Busy    = 1'b1;
                bus.MemAddr = DIN_LO_ADDR;
                state_nxt   = LD_DIV;
            end
            LD_DIV: begin
                bus.Busy    = 1'b1;
                bus.MemAddr = DIVISOR_ADDR;
                state_nxt   = (bus.MemRdData == 8'h00) ? WR_HI : DIVIDE;
            end
            DIVIDE: begin
                bus.Busy = 1'b1;
                if (cnt == 5'd0) state_nxt = WR_HI;
            end
            WR_HI: begin
                bus.Busy      = 1'b1;
                bus.MemWrEn   = 1'b1;
                bus.MemAddr   = RES_ADDR;
                bus.MemWrData = result[23:16];
                state_nxt     = WR_MID;
            end
            WR_MID: begin
                bus.Busy      = 1'b1;
                bus.MemWrEn   = 1'b1;
                bus.MemAddr   = RES_ADDR + AW'(1);
                bus.MemWrData = result[15:8];
                state_nxt     = WR_LO;
            end
            WR_LO: begin
                bus.Busy      = 1'b1;
                bus.MemWrEn   = 1'b1;
                bus.MemAddr   = RES_ADDR + AW'(2);
                bus.MemWrData = result[7:0];
                state_nxt     = DONE;
            end
            DONE: begin
                bus.Ack = 1'b1;
                if (launch) state_nxt = LD_HI;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_div2_sequencer.sv
// Drives a truncating (ROUND=0) and a rounding (ROUND=1) sequencer side by
// side against their own data memories and checks results and timing.
module tb_div2_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    int tests  = 0;
    int failed = 0;
    int wr0 = 0, wr1 = 0, bad0 = 0, bad1 = 0;

    always #5 clk = ~clk;

    div2_sequencer_if #(.AW(8)) bus0 ();
    div2_sequencer_if #(.AW(8)) bus1 ();

    assign bus0.Start     = start;
    assign bus1.Start     = start;
    assign bus0.MemRdData = mem0[bus0.MemAddr];
    assign bus1.MemRdData = mem1[bus1.MemAddr];

    div2_sequencer #(.AW(8), .ROUND(0)) dut0 (.Clk(clk), .Reset(reset), .bus(bus0.master));
    div2_sequencer #(.AW(8), .ROUND(1)) dut1 (.Clk(clk), .Reset(reset), .bus(bus1.master));

    always @(posedge clk) begin
        if (bus0.MemWrEn) begin
            mem0[bus0.MemAddr] <= bus0.MemWrData;
            wr0++;
            if (bus0.MemAddr < 8'd4 || bus0.MemAddr > 8'd6) bad0++;
        end
        if (bus1.MemWrEn) begin
            mem1[bus1.MemAddr] <= bus1.MemWrData;
            wr1++;
            if (bus1.MemAddr < 8'd4 || bus1.MemAddr > 8'd6) bad1++;
        end
    end

    typedef struct {
        logic [15:0] d;
        logic [7:0]  v;
        logic [23:0] e0;
        logic [23:0] e1;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // floor(d*256/v) in 24 bits; rounding adds the next binary digit unless saturated
    function automatic logic [23:0] model(input logic [15:0] d, input logic [7:0] v, input int r);
        longint num, q, g;
        if (v == 8'd0) return 24'hFF_FFFF;
        num = longint'(d) * 256;
        q   = (num / longint'(v)) % 64'h100_0000;
        g   = ((num * 2) / longint'(v)) % 2;
        if (r != 0 && q != 64'hFF_FFFF) q = q + g;
        return 24'(q);
    endfunction

    task automatic load_operands(input logic [15:0] d, input logic [7:0] v);
        mem0[0] = d[15:8]; mem0[1] = d[7:0]; mem0[2] = v;
        mem1[0] = d[15:8]; mem1[1] = d[7:0]; mem1[2] = v;
        for (int i = 4; i < 7; i++) begin
            mem0[i] = 8'hEE;
            mem1[i] = 8'hEE;
        end
    endtask

    task automatic run(input logic [15:0] d, input logic [7:0] v, input int hold,
                       input int glitch_at, input logic [23:0] e0, input logic [23:0] e1,
                       input string tag);
        int w0, w1, b0, b1, l0, l1, both;
        load_operands(d, v);
        w0 = wr0; w1 = wr1; b0 = bad0; b1 = bad1;
        l0 = 0; l1 = 0; both = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        check({tag, " ack0 after launch"}, 32'(bus0.Ack), 32'd0);
        check({tag, " busy1 after launch"}, 32'(bus1.Busy), 32'd1);
        for (int n = 1; n <= 60; n++) begin
            if (bus0.Ack && bus0.Busy) both++;
            if (bus1.Ack && bus1.Busy) both++;
            if (bus0.Ack && l0 == 0) l0 = n;
            if (bus1.Ack && l1 == 0) l1 = n;
            if (l0 != 0 && l1 != 0) break;
            start = (n < hold) || (glitch_at > 0 && n >= glitch_at && n < glitch_at + 2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, " latency r0"}, 32'(l0), (v == 8'd0) ? 32'd7 : 32'd31);
        check({tag, " latency r1"}, 32'(l1), (v == 8'd0) ? 32'd7 : 32'd32);
        check({tag, " busy0 in done"}, 32'(bus0.Busy), 32'd0);
        check({tag, " busy1 in done"}, 32'(bus1.Busy), 32'd0);
        check({tag, " ack&busy overlap"}, 32'(both), 32'd0);
        check({tag, " result r0"}, 32'({mem0[4], mem0[5], mem0[6]}), 32'(e0));
        check({tag, " result r1"}, 32'({mem1[4], mem1[5], mem1[6]}), 32'(e1));
        repeat (3) begin @(posedge clk); #1; end
        check({tag, " ack held"}, 32'({bus0.Ack, bus1.Ack}), 32'b11);
        check({tag, " write pulses r0"}, 32'(wr0 - w0), 32'd3);
        check({tag, " write pulses r1"}, 32'(wr1 - w1), 32'd3);
        check({tag, " stray writes"}, 32'((bad0 - b0) + (bad1 - b1)), 32'd0);
        check({tag, " operands r0"}, 32'({mem0[0], mem0[1], mem0[2]}), 32'({d, v}));
        check({tag, " operands r1"}, 32'({mem1[0], mem1[1], mem1[2]}), 32'({d, v}));
    endtask

    task automatic abort_in_divide();
        int w0, w1;
        load_operands(16'h7777, 8'd13);
        w0 = wr0; w1 = wr1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        // cycle 1 is LD_HI, DIVIDE starts in cycle 4, its 10th cycle is 13
        repeat (12) begin @(posedge clk); #1; end
        check("abort busy before reset", 32'(bus0.Busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort ack", 32'({bus0.Ack, bus1.Ack}), 32'd0);
        check("abort busy", 32'({bus0.Busy, bus1.Busy}), 32'd0);
        check("abort addr", 32'({bus0.MemAddr, bus1.MemAddr}), 32'd0);
        check("abort wren", 32'({bus0.MemWrEn, bus1.MemWrEn}), 32'd0);
        reset = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        check("abort idle ack", 32'({bus0.Ack, bus1.Ack}), 32'd0);
        check("abort no writes", 32'((wr0 - w0) + (wr1 - w1)), 32'd0);
        check("abort dm r0", 32'({mem0[4], mem0[5], mem0[6]}), 32'hEEEEEE);
        check("abort dm r1", 32'({mem1[4], mem1[5], mem1[6]}), 32'hEEEEEE);
    endtask

    initial begin
        logic [15:0] d;
        logic [7:0]  v;

        vecs[0] = '{16'd385,   8'd6,   24'h00402A, 24'h00402B};
        vecs[1] = '{16'd3,     8'd255, 24'h000003, 24'h000003};
        vecs[2] = '{16'd1,     8'd3,   24'h000055, 24'h000055};
        vecs[3] = '{16'd2,     8'd3,   24'h0000AA, 24'h0000AB};
        vecs[4] = '{16'hFFFF,  8'd1,   24'hFFFF00, 24'hFFFF00};
        vecs[5] = '{16'h1234,  8'd0,   24'hFFFFFF, 24'hFFFFFF};

        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset ack", 32'({bus0.Ack, bus1.Ack}), 32'd0);
        check("reset busy", 32'({bus0.Busy, bus1.Busy}), 32'd0);
        check("reset addr", 32'({bus0.MemAddr, bus1.MemAddr}), 32'd0);
        check("reset wren", 32'({bus0.MemWrEn, bus1.MemWrEn}), 32'd0);
        check("reset wdata", 32'({bus0.MemWrData, bus1.MemWrData}), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run(vecs[i].d, vecs[i].v, 1, 0, vecs[i].e0, vecs[i].e1, $sformatf("vec%0d", i));

        run(16'd1000, 8'd7, 4, 10, model(16'd1000, 8'd7, 0), model(16'd1000, 8'd7, 1), "held_start");
        run(16'hBEEF, 8'd200, 1, 0, model(16'hBEEF, 8'd200, 0), model(16'hBEEF, 8'd200, 1), "relaunch");

        abort_in_divide();
        run(16'd385, 8'd6, 1, 0, 24'h00402A, 24'h00402B, "after_abort");

        for (int i = 0; i < 1000; i++) begin
            d = 16'($urandom);
            v = 8'($urandom_range(1, 255));
            run(d, v, 1, 0, model(d, v, 0), model(d, v, 1), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/div2_sequencer.md
Name: div2_sequencer

Overview:
Hardware sequencer for program 2 (16-bit dividend / 8-bit divisor -> 24-bit fixed-point quotient, 16 integer + 8 fraction bits). It fetches the operands from data memory, runs a bit-serial restoring division, writes the 3-byte result back to data memory and raises Ack. It sits beside the CPU core as a memory-port master and shares the core's Start/Ack launch protocol.

Parameters:
AW, 8, data-memory address width
DIN_HI_ADDR, 0, address of dividend[15:8]
DIN_LO_ADDR, 1, address of dividend[7:0]
DIVISOR_ADDR, 2, address of 8-bit divisor
RES_ADDR, 4, base address of result; bytes at RES_ADDR (q[23:16]), +1 (q[15:8]), +2 (q[7:0])
ROUND, 0, 0 = truncate; 1 = half-LSB upward rounding with saturation

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  launch request; rising edge (sampled, registered) starts a run
Ack  output  1  run complete; held high in DONE
Busy  output  1  high from launch until DONE entered
MemAddr  output  AW  data-memory address
MemWrEn  output  1  data-memory write enable (write on Clk edge)
MemWrData  output  8  data-memory write data
MemRdData  input  8  data-memory read data, combinational (same-cycle) read of MemAddr

Behaviour:
- Reset (sync, active-high): state IDLE; Ack=0, Busy=0, MemWrEn=0, MemAddr=0, MemWrData=0; Start edge register cleared to 0. Reset mid-run aborts immediately; no further memory writes.
- Launch = Start high while registered Start_q low. Evaluated only in IDLE or DONE; ignored while Busy. Start held high does not relaunch.
- States: IDLE -> LD_HI -> LD_LO -> LD_DIV -> DIVIDE -> WR_HI -> WR_MID -> WR_LO -> DONE. DONE -> LD_HI on launch (Ack drops the same edge).
- LD_HI/LD_LO/LD_DIV: drive MemAddr to the respective address, capture MemRdData at end of cycle into dividend/divisor registers.
- LD_DIV: if captured divisor == 0, load quotient = 24'hFFFFFF and go straight to WR_HI; else clear 9-bit remainder, load cycle counter, go to DIVIDE.
- DIVIDE: numerator N = {dividend, 8'h00} (24 bits), one quotient bit per cycle MSB first: rem = {rem[7:0], N[i]}; if rem >= divisor then rem -= divisor, q[i]=1 else q[i]=0. 24 cycles with ROUND=0; 25 with ROUND=1 (extra cycle yields guard bit from N bit -1 = 0).
- ROUND=1: result = q + guard; if q == 24'hFFFFFF result stays 24'hFFFFFF (saturate, no wrap).
- Result equals floor(dividend*256/divisor) truncated to 24 bits (ROUND=0).
- WR_HI/WR_MID/WR_LO: MemWrEn=1 for exactly one cycle each, MemAddr = RES_ADDR, +1, +2, MemWrData = result bytes high to low. MemWrEn=0 in every other state.
- Latency (ROUND=0, divisor!=0): launch sampled at edge T0; LD_HI in cycle T1; DIVIDE T4..T27; writes T28..T30; Ack=1 from T31. ROUND=1: Ack from T32. Divisor 0: writes T4..T6, Ack from T7.
- Busy=1 in LD_HI..WR_LO; Ack=1 only in DONE; never both high.
- Operand memory locations are never written; only RES_ADDR..RES_ADDR+2 are written.

Test Plan:
- Dividend 385 (0x0181), divisor 6 -> DM[4..6] = 00,40,2A; Ack high exactly 31 cycles after the launch edge; Busy low once Ack is high.
- Dividend 3, divisor 255 -> 00,00,03; dividend 1, divisor 3 -> 00,00,55; ROUND=1 with 1/3 -> 00,00,55; with 2/3 (exact 170.67) -> 00,00,AB.
- Dividend 0xFFFF, divisor 1 -> FF,FF,00; divisor 0 with any dividend -> FF,FF,FF with Ack after 7 cycles and no DIVIDE state entered.
- Start held high 4 cycles then low; second rising edge while Busy -> ignored, single run, exactly 3 write pulses; new edge in DONE -> Ack drops next cycle, second run completes with correct result.
- Reset asserted in DIVIDE cycle 10 -> next cycle IDLE, Ack=0, Busy=0, no writes to DM[4..6] (pre-filled 0xEE bytes unchanged).
- Random 1000 operand pairs (divisor 1..255), both ROUND values -> DM[4..6] matches model floor(d*256/v) (+ rounding/saturation rule); DM[0..2] unchanged.
